// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks the program ROM, assembles 1- or 2-byte
// instructions and presents them to execute with a valid/ready handshake.
// A redirect from execute reloads the fetch address and flushes the
// partially fetched instruction.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] NOP_BYTE = 8'h70
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_byte0,
    output logic [7:0] instr_byte1,
    output logic       instr_two_byte,
    output logic [1:0] instr_class,
    output logic [1:0] instr_rd,
    output logic [1:0] instr_rs,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_target
);

    typedef enum logic [1:0] {F1, F2, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] byte0_nxt, byte1_nxt, ipc_nxt;

    // Length is decided from the opcode byte alone.
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:4] == 4'b1000) || (b[7:5] == 3'b101);
    endfunction

    assign address_bus = pc;

    // Next-state and datapath-load selection; redirect overrides everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        byte0_nxt = instr_byte0;
        byte1_nxt = instr_byte1;
        ipc_nxt   = instr_pc;
        case (state)
            F1: begin
                byte0_nxt = data_bus;
                byte1_nxt = 8'h00;
                ipc_nxt   = pc;
                pc_nxt    = pc + 8'd1;
                state_nxt = is_two_byte(data_bus) ? F2 : HOLD;
            end
            F2: begin
                byte1_nxt = data_bus;
                pc_nxt    = pc + 8'd1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (instr_ready) state_nxt = F1;
            end
            default: state_nxt = F1;
        endcase
        // A redirect discards whatever this cycle would have loaded; the held
        // instruction (if any) is treated as consumed.
        if (redirect) begin
            pc_nxt    = redirect_target;
            state_nxt = F1;
            byte0_nxt = instr_byte0;
            byte1_nxt = instr_byte1;
            ipc_nxt   = instr_pc;
        end
    end

    // State, pc and instruction registers; valid is registered off next state
    // so it is high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= F1;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_byte0 <= NOP_BYTE;
            instr_byte1 <= 8'h00;
            instr_pc    <= 8'h00;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= (state_nxt == HOLD);
            instr_byte0 <= byte0_nxt;
            instr_byte1 <= byte1_nxt;
            instr_pc    <= ipc_nxt;
        end
    end

    // Field decode straight off the held opcode byte (only registers feed it).
    always_comb begin
        instr_two_byte = is_two_byte(instr_byte0);
        if (instr_byte0[7:5] == 3'b101)       instr_class = 2'd3;
        else if (instr_byte0[7:4] == 4'b1000) instr_class = 2'd2;
        else if (instr_byte0[7:4] == 4'b1001) instr_class = 2'd1;
        else                                  instr_class = 2'd0;
        if (instr_class == 2'd0) begin
            instr_rd = instr_byte0[3:2];
            instr_rs = instr_byte0[1:0];
        end else begin
            instr_rd = instr_byte0[1:0];
            instr_rs = 2'b00;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready, redirect;
    logic [7:0] target;

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    logic [7:0] addr_a, data_a, b0_a, b1_a, pc_a;
    logic       valid_a, two_a;
    logic [1:0] cls_a, rd_a, rs_a;

    logic [7:0] addr_b, data_b, b0_b, b1_b, pc_b;
    logic       valid_b, two_b;
    logic [1:0] cls_b, rd_b, rs_b;

    int checks = 0;
    int failures = 0;

    assign data_a = rom_a[addr_a];
    assign data_b = rom_b[addr_b];

    always #5 clk = ~clk;

    instruction_fetch dut_a (
        .clk(clk), .reset(reset), .address_bus(addr_a), .data_bus(data_a),
        .instr_valid(valid_a), .instr_ready(ready), .instr_byte0(b0_a),
        .instr_byte1(b1_a), .instr_two_byte(two_a), .instr_class(cls_a),
        .instr_rd(rd_a), .instr_rs(rs_a), .instr_pc(pc_a),
        .redirect(redirect), .redirect_target(target)
    );

    instruction_fetch #(.RESET_PC(8'hFF)) dut_b (
        .clk(clk), .reset(reset), .address_bus(addr_b), .data_bus(data_b),
        .instr_valid(valid_b), .instr_ready(1'b0), .instr_byte0(b0_b),
        .instr_byte1(b1_b), .instr_two_byte(two_b), .instr_class(cls_b),
        .instr_rd(rd_b), .instr_rs(rs_b), .instr_pc(pc_b),
        .redirect(1'b0), .redirect_target(8'h00)
    );

    typedef struct {
        logic [7:0] b0;
        logic       two;
        logic [1:0] cls;
        logic [1:0] rd;
        logic [1:0] rs;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_instr(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic two, input logic [1:0] cls, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [7:0] ipc, input logic [7:0] addr);
        chk({nm, "_valid"}, valid_a, 1);
        chk({nm, "_b0"}, b0_a, b0);
        chk({nm, "_b1"}, b1_a, b1);
        chk({nm, "_two"}, two_a, two);
        chk({nm, "_cls"}, cls_a, cls);
        chk({nm, "_rd"}, rd_a, rd);
        chk({nm, "_rs"}, rs_a, rs);
        chk({nm, "_pc"}, pc_a, ipc);
        chk({nm, "_addr"}, addr_a, addr);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{8'h26, 1'b0, 2'd0, 2'd1, 2'd2};
        tbl[1] = '{8'h00, 1'b0, 2'd0, 2'd0, 2'd0};
        tbl[2] = '{8'h70, 1'b0, 2'd0, 2'd0, 2'd0};
        tbl[3] = '{8'h8F, 1'b1, 2'd2, 2'd3, 2'd0};
        tbl[4] = '{8'h93, 1'b0, 2'd1, 2'd3, 2'd0};
        tbl[5] = '{8'hA1, 1'b1, 2'd3, 2'd1, 2'd0};
        tbl[6] = '{8'hBE, 1'b1, 2'd3, 2'd2, 2'd0};
        tbl[7] = '{8'hC7, 1'b0, 2'd0, 2'd1, 2'd3};
        tbl[8] = '{8'hFF, 1'b0, 2'd0, 2'd3, 2'd3};
        tbl[9] = '{8'h9C, 1'b0, 2'd1, 2'd0, 2'd0};

        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 8'h00;
            rom_b[i] = 8'h00;
        end
        rom_a[8'h00] = 8'h81; rom_a[8'h01] = 8'h00;
        rom_a[8'h04] = 8'h98;
        rom_b[8'hFF] = 8'hA8; rom_b[8'h00] = 8'h1A;

        reset = 1'b1; ready = 1'b0; redirect = 1'b0; target = 8'h00;
        #12;
        // Reset state
        chk("rst_valid", valid_a, 0);
        chk("rst_b0", b0_a, 8'h70);
        chk("rst_b1", b1_a, 0);
        chk("rst_two", two_a, 0);
        chk("rst_cls", cls_a, 0);
        chk("rst_rd", rd_a, 0);
        chk("rst_rs", rs_a, 0);
        chk("rst_pc", pc_a, 0);
        chk("rst_addr", addr_a, 8'h00);
        chk("rst_addr_b", addr_b, 8'hFF);

        // T1: reset release, 2-byte immediate at 00
        tick(); reset = 1'b0;
        chk("t1_addr0", addr_a, 8'h00);
        tick();
        chk("t1_addr1", addr_a, 8'h01);
        chk("t1_nvalid", valid_a, 0);
        tick();
        chk_instr("t1", 8'h81, 8'h00, 1'b1, 2'd2, 2'd1, 2'd0, 8'h00, 8'h02);
        // T5: second instance from RESET_PC=FF straddling the wrap
        chk("t5_valid", valid_b, 1);
        chk("t5_b0", b0_b, 8'hA8);
        chk("t5_b1", b1_b, 8'h1A);
        chk("t5_cls", cls_b, 3);
        chk("t5_two", two_b, 1);
        chk("t5_pc", pc_b, 8'hFF);
        chk("t5_addr", addr_b, 8'h01);

        // T2: redirect from HOLD (ready low) to 04
        redirect = 1'b1; target = 8'h04;
        tick(); redirect = 1'b0;
        chk("t2_addr", addr_a, 8'h04);
        chk("t2_nvalid", valid_a, 0);
        tick();
        chk_instr("t2", 8'h98, 8'h00, 1'b0, 2'd1, 2'd0, 2'd0, 8'h04, 8'h05);

        // T3: ADD R1,R2 at 00 held for 5 cycles with ready low
        rom_a[8'h00] = 8'h26;
        redirect = 1'b1; target = 8'h00;
        tick(); redirect = 1'b0;
        tick();
        chk_instr("t3", 8'h26, 8'h00, 1'b0, 2'd0, 2'd1, 2'd2, 8'h00, 8'h01);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_valid", valid_a, 1);
            chk("t3_hold_b0", b0_a, 8'h26);
            chk("t3_hold_addr", addr_a, 8'h01);
            chk("t3_hold_pc", pc_a, 8'h00);
        end
        ready = 1'b1;
        tick(); ready = 1'b0;
        chk("t3_drop_valid", valid_a, 0);
        chk("t3_fetch_addr", addr_a, 8'h01);
        tick();
        chk_instr("t3_next", 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 8'h01, 8'h02);

        // T4: ready and redirect together in HOLD; redirect wins
        ready = 1'b1; redirect = 1'b1; target = 8'h04;
        tick(); ready = 1'b0; redirect = 1'b0;
        chk("t4_addr", addr_a, 8'h04);
        chk("t4_nvalid", valid_a, 0);
        tick();
        chk_instr("t4", 8'h98, 8'h00, 1'b0, 2'd1, 2'd0, 2'd0, 8'h04, 8'h05);

        // Table of decode vectors fetched at 20 (byte at 21 is 5C)
        rom_a[8'h21] = 8'h5C;
        for (int i = 0; i < 10; i++) begin
            int n;
            rom_a[8'h20] = tbl[i].b0;
            redirect = 1'b1; target = 8'h20;
            tick(); redirect = 1'b0;
            n = 0;
            while (!valid_a && n < 5) begin
                tick();
                n++;
            end
            chk_instr("tbl", tbl[i].b0, tbl[i].two ? 8'h5C : 8'h00, tbl[i].two,
                      tbl[i].cls, tbl[i].rd, tbl[i].rs, 8'h20,
                      tbl[i].two ? 8'h22 : 8'h21);
        end

        // Redirect during F2 discards the partial 2-byte fetch
        rom_a[8'h30] = 8'h81; rom_a[8'h31] = 8'h44; rom_a[8'h40] = 8'h26;
        redirect = 1'b1; target = 8'h30;
        tick(); redirect = 1'b0;
        tick();
        chk("rf2_addr", addr_a, 8'h31);
        redirect = 1'b1; target = 8'h40;
        tick(); redirect = 1'b0;
        chk("rf2_raddr", addr_a, 8'h40);
        chk("rf2_nvalid", valid_a, 0);
        tick();
        chk_instr("rf2", 8'h26, 8'h00, 1'b0, 2'd0, 2'd1, 2'd2, 8'h40, 8'h41);

        // T6: reset asserted mid-cycle during F2
        rom_a[8'h00] = 8'h81; rom_a[8'h01] = 8'h00;
        redirect = 1'b1; target = 8'h30;
        tick(); redirect = 1'b0;
        tick();
        chk("t6_inf2_addr", addr_a, 8'h31);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", valid_a, 0);
        chk("t6_addr", addr_a, 8'h00);
        chk("t6_b0", b0_a, 8'h70);
        chk("t6_b1", b1_a, 8'h00);
        chk("t6_two", two_a, 0);
        chk("t6_addr_b", addr_b, 8'hFF);
        tick(); reset = 1'b0;
        tick();
        chk("t6_refetch_addr", addr_a, 8'h01);
        tick();
        chk_instr("t6", 8'h81, 8'h00, 1'b1, 2'd2, 2'd1, 2'd0, 8'h00, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
